// File: rtl/cdc_pkg.sv
// ----------------------------------------------------------------------------
// cdc_pkg
// Shared definitions for the 4-phase req/ack clock-domain-crossing blocks.
//   cdc_hs_state_e : destination-side handshake controller states
//   SYNC_MIN/MAX   : legal range of synchronizer depth
// ----------------------------------------------------------------------------
package cdc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        VALID = 2'd1,
        ACK   = 2'd2
    } cdc_hs_state_e;

    localparam int SYNC_MIN = 2;
    localparam int SYNC_MAX = 4;

endpackage

// File: rtl/cdc_sync_nff_ar.sv
// ----------------------------------------------------------------------------
// cdc_sync_nff_ar
// Multi-flop level synchronizer for a single asynchronous bit.
// Ports:
//   clk   in  destination clock
//   rst   in  asynchronous active-high reset, clears the whole chain to 0
//   d_i   in  asynchronous input level
//   q_o   out synchronized level, STAGES clk edges behind d_i
// ----------------------------------------------------------------------------
module cdc_sync_nff_ar #(
    parameter int STAGES = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/cdc_hs_rx_ctrl.sv
// ----------------------------------------------------------------------------
// cdc_hs_rx_ctrl
// Destination-side controller for a 4-phase req/ack crossing of a DW-bit
// word. The request level is synchronized; the data bus is sampled only once
// the synchronized request is seen, when the source guarantees it is stable.
// The word is then offered to a local valid/ready consumer and the
// acknowledge is returned once the consumer takes it.
// Ports:
//   clk         in   local clock
//   rst         in   asynchronous active-high reset
//   async_req   in   source request level (foreign domain)
//   async_data  in   source data, stable while async_req is high
//   async_ack   out  registered acknowledge level back to the source
//   out_valid   out  captured word available
//   out_ready   in   local consumer accepts the word
//   out_data    out  captured word, stable while out_valid
//   proto_err   out  one-cycle pulse: request withdrawn before acceptance
//   xfer_cnt    out  completed transfers, wraps modulo 2^CW
// ----------------------------------------------------------------------------
module cdc_hs_rx_ctrl
    import cdc_pkg::*;
#(
    parameter int DW          = 32,
    parameter int SYNC_STAGES = 3,
    parameter int CW          = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          async_req,
    input  logic [DW-1:0] async_data,
    output logic          async_ack,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          proto_err,
    output logic [CW-1:0] xfer_cnt
);

    if (SYNC_STAGES < SYNC_MIN || SYNC_STAGES > SYNC_MAX) begin : g_bad_sync
        $error("cdc_hs_rx_ctrl: SYNC_STAGES out of legal range");
    end

    logic          req_s;
    logic          req_prev_q;
    cdc_hs_state_e state_q;
    logic          ack_q;
    logic          valid_q;
    logic [DW-1:0] data_q;
    logic          perr_q;
    logic [CW-1:0] cnt_q;

    cdc_sync_nff_ar #(
        .STAGES (SYNC_STAGES)
    ) u_req_sync (
        .clk (clk),
        .rst (rst),
        .d_i (async_req),
        .q_o (req_s)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            ack_q      <= 1'b0;
            valid_q    <= 1'b0;
            data_q     <= '0;
            perr_q     <= 1'b0;
            cnt_q      <= '0;
            req_prev_q <= 1'b0;
        end else begin
            req_prev_q <= req_s;
            perr_q     <= 1'b0;
            case (state_q)
                IDLE: begin
                    // ack is always low here, so a high req_s is a fresh request
                    if (req_s) begin
                        data_q  <= async_data;
                        valid_q <= 1'b1;
                        state_q <= VALID;
                    end
                end
                VALID: begin
                    // Request withdrawn before the word was taken: flag it, but
                    // still let the local transfer complete normally.
                    if (req_prev_q && !req_s) begin
                        perr_q <= 1'b1;
                    end
                    if (valid_q && out_ready) begin
                        valid_q <= 1'b0;
                        ack_q   <= 1'b1;
                        cnt_q   <= cnt_q + CW'(1);
                        state_q <= ACK;
                    end
                end
                ACK: begin
                    // Return to IDLE only after the source has dropped req,
                    // so the same request is never captured twice.
                    if (!req_s) begin
                        ack_q   <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                    ack_q   <= 1'b0;
                end
            endcase
        end
    end

    assign async_ack = ack_q;
    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign proto_err = perr_q;
    assign xfer_cnt  = cnt_q;

endmodule

// File: tb/tb_cdc_hs_rx_ctrl.sv
// ----------------------------------------------------------------------------
// tb_cdc_hs_rx_ctrl
// Self-checking bench for cdc_hs_rx_ctrl (DW=32, SYNC_STAGES=3, CW=4).
// Inputs change and outputs are sampled on the falling clock edge.
// ----------------------------------------------------------------------------
module tb_cdc_hs_rx_ctrl;

    localparam int DW = 32;
    localparam int SS = 3;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          async_req = 1'b0;
    logic [DW-1:0] async_data = '0;
    logic          async_ack;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic          proto_err;
    logic [CW-1:0] xfer_cnt;

    int total = 0;
    int bad   = 0;
    logic [CW-1:0] exp_cnt;

    cdc_hs_rx_ctrl #(
        .DW          (DW),
        .SYNC_STAGES (SS),
        .CW          (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .async_req  (async_req),
        .async_data (async_data),
        .async_ack  (async_ack),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .proto_err  (proto_err),
        .xfer_cnt   (xfer_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          req;
        logic [DW-1:0] data;
        logic          ready;
        logic          exp_valid;
        logic          exp_ack;
        logic          exp_perr;
        logic [DW-1:0] exp_data;
        logic [CW-1:0] exp_cnt;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic sig(input int sel);
        return (sel == 0) ? out_valid : async_ack;
    endfunction

    // Bounded wait on out_valid (sel=0) or async_ack (sel=1); a timeout is a failed comparison.
    task automatic wait_sig(input string nm, input int sel, input logic val, input int maxc,
                            output int n);
        n = 0;
        while (sig(sel) !== val && n < maxc) begin
            tick();
            n++;
        end
        if (sig(sel) !== val) chk(nm, {63'd0, sig(sel)}, {63'd0, val});
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        exp_cnt = '0;
    endtask

    initial begin
        int n;
        int busy;
        int perr_cnt;

        // ---------------- reset and idle ----------------
        exp_cnt = '0;
        rst = 1'b1;
        async_req = 1'b0;
        tick(); tick(); tick();
        chk("reset_outputs", {out_valid, async_ack, proto_err, xfer_cnt, out_data},
            '0);
        rst = 1'b0;
        busy = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (out_valid || async_ack || proto_err || xfer_cnt != 0) busy++;
        end
        chk("idle_20_cycles", busy, 0);

        // ---------------- table: basic transfer, ready high ----------------
        //            req data          rdy  vld ack perr exp_data      cnt
        vecs[0] = '{1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        4'd0};
        vecs[1] = '{1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        4'd0};
        vecs[2] = '{1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        4'd0};
        vecs[3] = '{1'b1, 32'hDEADBEEF, 1'b1, 1'b1, 1'b0, 1'b0, 32'hDEADBEEF, 4'd0};
        vecs[4] = '{1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF, 4'd1};
        vecs[5] = '{1'b0, 32'hDEADBEEF, 1'b1, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF, 4'd1};
        vecs[6] = '{1'b0, 32'hDEADBEEF, 1'b1, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF, 4'd1};
        vecs[7] = '{1'b0, 32'hDEADBEEF, 1'b1, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF, 4'd1};
        vecs[8] = '{1'b0, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF, 4'd1};
        vecs[9] = '{1'b0, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF, 4'd1};
        for (int i = 0; i < 10; i++) begin
            async_req  = vecs[i].req;
            async_data = vecs[i].data;
            out_ready  = vecs[i].ready;
            tick();
            chk($sformatf("vec%0d", i),
                {out_valid, async_ack, proto_err, xfer_cnt, out_data},
                {vecs[i].exp_valid, vecs[i].exp_ack, vecs[i].exp_perr,
                 vecs[i].exp_cnt, vecs[i].exp_data});
        end
        exp_cnt = 4'd1;

        // ---------------- backpressure ----------------
        async_data = 32'h12345678;
        async_req  = 1'b1;
        out_ready  = 1'b0;
        wait_sig("bp_valid_timeout", 0, 1'b1, 20, n);
        chk("bp_latency", n, SS + 1);
        busy = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (!out_valid || async_ack || out_data !== 32'h12345678) busy++;
        end
        chk("bp_hold_10", busy, 0);
        out_ready = 1'b1;
        tick();
        exp_cnt++;
        chk("bp_accept", {out_valid, async_ack, xfer_cnt}, {1'b0, 1'b1, exp_cnt});
        tick();
        chk("bp_single_accept", {out_valid, async_ack, xfer_cnt}, {1'b0, 1'b1, exp_cnt});
        async_req = 1'b0;
        out_ready = 1'b0;
        wait_sig("bp_ack_drop_timeout", 1, 1'b0, 20, n);
        chk("bp_ack_drop_latency", n, SS + 1);

        // ---------------- request withdrawn early ----------------
        async_data = 32'hA5A5C3C3;
        async_req  = 1'b1;
        out_ready  = 1'b0;
        wait_sig("perr_valid_timeout", 0, 1'b1, 20, n);
        async_req = 1'b0;
        perr_cnt = 0;
        busy = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (proto_err) perr_cnt++;
            if (!out_valid || out_data !== 32'hA5A5C3C3) busy++;
        end
        chk("perr_one_pulse", perr_cnt, 1);
        chk("perr_valid_held", busy, 0);
        out_ready = 1'b1;
        tick();
        exp_cnt++;
        chk("perr_accept", {out_valid, async_ack, xfer_cnt}, {1'b0, 1'b1, exp_cnt});
        out_ready = 1'b0;
        wait_sig("perr_ack_drop_timeout", 1, 1'b0, SS + 1, n);
        chk("perr_no_recapture", out_valid, 1'b0);

        // ---------------- reset while in ACK with req held ----------------
        async_data = 32'h5A5A0001;
        async_req  = 1'b1;
        out_ready  = 1'b1;
        wait_sig("rst_ack_timeout", 1, 1'b1, 20, n);
        rst = 1'b1;
        #1;
        chk("rst_ack_immediate", {async_ack, out_valid, xfer_cnt}, '0);
        exp_cnt = '0;
        tick();
        tick();
        rst = 1'b0;
        out_ready = 1'b0;
        for (int i = 1; i <= SS + 1; i++) begin
            tick();
            if (i <= SS) chk($sformatf("rst_recap_wait%0d", i), out_valid, 1'b0);
            else chk("rst_recapture", {out_valid, out_data}, {1'b1, 32'h5A5A0001});
        end
        out_ready = 1'b1;
        tick();
        exp_cnt++;
        chk("rst_recap_accept", {async_ack, xfer_cnt}, {1'b1, exp_cnt});
        async_req = 1'b0;
        out_ready = 1'b0;
        wait_sig("rst_ack_drop_timeout", 1, 1'b0, 20, n);

        // ---------------- 17 back-to-back transfers, CW=4 wrap ----------------
        do_reset();
        out_ready = 1'b1;
        for (int t = 0; t < 17; t++) begin
            async_data = 32'h600D0000 + t;
            async_req  = 1'b1;
            wait_sig($sformatf("b2b_ack_hi%0d", t), 1, 1'b1, 20, n);
            chk($sformatf("b2b_data%0d", t), out_data, 32'h600D0000 + t);
            exp_cnt++;
            async_req = 1'b0;
            wait_sig($sformatf("b2b_ack_lo%0d", t), 1, 1'b0, 20, n);
        end
        chk("b2b_wrap_cnt", xfer_cnt, 4'd1);
        out_ready = 1'b0;

        // ---------------- randomized source and consumer ----------------
        begin
            logic [DW-1:0] exp_q[$];
            logic [DW-1:0] hold_data;
            logic          hold_valid;
            int            src_st;
            int            src_dly;
            int            tmo;
            int            accepts;
            hold_valid = 1'b0;
            hold_data  = '0;
            src_st     = 0;
            src_dly    = 2;
            tmo        = 0;
            accepts    = 0;
            perr_cnt   = 0;
            for (int c = 0; c < 4000; c++) begin
                tick();
                // A word not taken must still be offered, unchanged.
                if (hold_valid) begin
                    chk("rand_hold", {out_valid, out_data}, {1'b1, hold_data});
                end
                if (proto_err) perr_cnt++;
                out_ready = ($urandom_range(0, 3) != 0);
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("rand_spurious_word", out_data, 64'hFFFF_FFFF_FFFF_FFFF);
                    end else begin
                        chk("rand_data", out_data, exp_q.pop_front());
                    end
                    accepts++;
                    exp_cnt++;
                end
                hold_valid = out_valid && !out_ready;
                hold_data  = out_data;
                // 4-phase source: raise req with new data, wait ack, drop req, wait ack low.
                tmo++;
                case (src_st)
                    0: if (src_dly == 0) begin
                           async_data = $urandom;
                           exp_q.push_back(async_data);
                           async_req = 1'b1;
                           src_st = 1;
                           tmo = 0;
                       end else src_dly--;
                    1: if (async_ack) begin
                           src_dly = $urandom_range(0, 5);
                           src_st = 2;
                       end
                    2: if (src_dly == 0) begin
                           async_req = 1'b0;
                           src_st = 3;
                           tmo = 0;
                       end else src_dly--;
                    default: if (!async_ack) begin
                           src_dly = $urandom_range(0, 5);
                           src_st = 0;
                       end
                endcase
                if (tmo > 200) begin
                    chk("rand_handshake_timeout", tmo, 0);
                    break;
                end
            end
            tick();
            chk("rand_cnt", xfer_cnt, exp_cnt);
            chk("rand_no_perr", perr_cnt, 0);
            chk("rand_enough_xfers", (accepts > 50), 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
